// File: rtl/xgri_gen2_if.sv
// CPU register port plus memory-manager drain port of the XG register interface.
// Latency: none (wires only).
// Backpressure: cpu_stall toward the CPU side; p_full/a_full pace the drain side.
interface xgri_gen2_if;
    logic [2:0]  cpu_addr;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [15:0] cpu_data;
    logic [15:0] cpu_q;
    logic        cpu_stall;
    logic        p_full;
    logic        a_full;
    logic        p_pop;
    logic        a_pop;
    logic [15:0] p_data;
    logic [15:0] a_data;
    logic [11:0] par;
    logic [14:0] aar;

    modport master (
        output cpu_addr, cpu_wren, cpu_rden, cpu_data, p_pop, a_pop,
        input  cpu_q, cpu_stall, p_full, a_full, p_data, a_data, par, aar
    );

    modport slave (
        input  cpu_addr, cpu_wren, cpu_rden, cpu_data, p_pop, a_pop,
        output cpu_q, cpu_stall, p_full, a_full, p_data, a_data, par, aar
    );
endinterface

// File: rtl/xgri_gen2.sv
// Stages CPU pattern/attribute words into tile buffers and hands full buffers to the memory manager.
// Latency: full flag one cycle after the filling push; cpu_q one cycle after cpu_rden.
// Backpressure: data-port writes stall while the target buffer drains; PAR/AAR writes never stall.
module xgri_gen2 #(
    parameter int P_DEPTH  = 16,
    parameter int A_DEPTH  = 4,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    xgri_gen2_if.slave  bus
);

    localparam int PPW = $clog2(P_DEPTH);
    localparam int APW = $clog2(A_DEPTH);
    localparam int PCW = $clog2(P_DEPTH + 1);
    localparam int ACW = $clog2(A_DEPTH + 1);

    localparam logic [PCW-1:0] P_LAST = PCW'(P_DEPTH - 1);
    localparam logic [ACW-1:0] A_LAST = ACW'(A_DEPTH - 1);
    localparam logic [PCW-1:0] P_ONE  = PCW'(1);
    localparam logic [ACW-1:0] A_ONE  = ACW'(1);

    localparam logic [2:0] ADDR_PAR    = 3'd0;
    localparam logic [2:0] ADDR_AAR    = 3'd1;
    localparam logic [2:0] ADDR_PDATA  = 3'd2;
    localparam logic [2:0] ADDR_ADATA  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} buf_state_t;

    buf_state_t p_state, p_state_nxt;
    buf_state_t a_state, a_state_nxt;

    logic [15:0]    p_mem [P_DEPTH];
    logic [15:0]    a_mem [A_DEPTH];
    logic [PPW-1:0] p_wr_ptr, p_rd_ptr;
    logic [APW-1:0] a_wr_ptr, a_rd_ptr;
    logic [PCW-1:0] p_count;
    logic [ACW-1:0] a_count;

    logic [11:0] par_reg, par_lat;
    logic [14:0] aar_reg, aar_lat;

    logic p_wr, a_wr, p_push, a_push;
    logic p_pop_ok, a_pop_ok;
    logic p_fill_done, a_fill_done, p_drain_done, a_drain_done;

    always_comb begin
        p_wr         = bus.cpu_wren && (bus.cpu_addr == ADDR_PDATA);
        a_wr         = bus.cpu_wren && (bus.cpu_addr == ADDR_ADATA);
        p_push       = p_wr && (p_state == FILL);
        a_push       = a_wr && (a_state == FILL);
        p_fill_done  = p_push && (p_count == P_LAST);
        a_fill_done  = a_push && (a_count == A_LAST);
        // Pops are only honoured while draining; stray pops during fill are dropped.
        p_pop_ok     = bus.p_pop && (p_state == DRAIN);
        a_pop_ok     = bus.a_pop && (a_state == DRAIN);
        p_drain_done = p_pop_ok && (p_count == P_ONE);
        a_drain_done = a_pop_ok && (a_count == A_ONE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= FILL;
            a_state <= FILL;
        end else begin
            p_state <= p_state_nxt;
            a_state <= a_state_nxt;
        end
    end

    always_comb begin
        p_state_nxt = p_state;
        a_state_nxt = a_state;
        case (p_state)
            FILL:    if (p_fill_done)  p_state_nxt = DRAIN;
            DRAIN:   if (p_drain_done) p_state_nxt = FILL;
            default: p_state_nxt = FILL;
        endcase
        case (a_state)
            FILL:    if (a_fill_done)  a_state_nxt = DRAIN;
            DRAIN:   if (a_drain_done) a_state_nxt = FILL;
            default: a_state_nxt = FILL;
        endcase
    end

    always_comb begin
        bus.p_full    = (p_state == DRAIN);
        bus.a_full    = (a_state == DRAIN);
        bus.cpu_stall = (p_wr && (p_state == DRAIN)) || (a_wr && (a_state == DRAIN));
        bus.p_data    = p_mem[p_rd_ptr];
        bus.a_data    = a_mem[a_rd_ptr];
        bus.par       = par_lat;
        bus.aar       = aar_lat;
    end

    // Buffer storage needs no reset: counts and pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (p_push) p_mem[p_wr_ptr] <= bus.cpu_data;
        if (a_push) a_mem[a_wr_ptr] <= bus.cpu_data;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            p_wr_ptr <= '0;
            p_rd_ptr <= '0;
            p_count  <= '0;
            a_wr_ptr <= '0;
            a_rd_ptr <= '0;
            a_count  <= '0;
        end else begin
            if (p_push) begin
                p_wr_ptr <= p_wr_ptr + 1'b1;
                p_count  <= p_count + 1'b1;
            end else if (p_pop_ok) begin
                p_rd_ptr <= p_rd_ptr + 1'b1;
                p_count  <= p_count - 1'b1;
            end
            if (a_push) begin
                a_wr_ptr <= a_wr_ptr + 1'b1;
                a_count  <= a_count + 1'b1;
            end else if (a_pop_ok) begin
                a_rd_ptr <= a_rd_ptr + 1'b1;
                a_count  <= a_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            par_reg <= '0;
            aar_reg <= '0;
            par_lat <= '0;
            aar_lat <= '0;
        end else begin
            if (bus.cpu_wren && (bus.cpu_addr == ADDR_PAR))
                par_reg <= bus.cpu_data[11:0];
            else if (AUTO_INC && p_fill_done)
                par_reg <= par_reg + 12'd1;
            // AAR stays burst aligned; the +4 step wraps naturally at 15 bits.
            if (bus.cpu_wren && (bus.cpu_addr == ADDR_AAR))
                aar_reg <= {bus.cpu_data[14:2], 2'b00};
            else if (AUTO_INC && a_fill_done)
                aar_reg <= aar_reg + 15'd4;
            if (p_fill_done) par_lat <= par_reg;
            if (a_fill_done) aar_lat <= aar_reg;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bus.cpu_q <= '0;
        end else if (bus.cpu_rden) begin
            case (bus.cpu_addr)
                ADDR_PAR:    bus.cpu_q <= {4'h0, par_reg};
                ADDR_AAR:    bus.cpu_q <= {1'b0, aar_reg};
                ADDR_STATUS: bus.cpu_q <= {5'h0, 3'(a_count), 5'(p_count), 1'b0,
                                           a_state == DRAIN, p_state == DRAIN};
                default:     bus.cpu_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xgri_gen2.sv
// Directed bench for xgri_gen2 with a queue-based reference model checked every cycle.
module tb_xgri_gen2;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    bit   chk_en  = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    xgri_gen2_if bus();

    xgri_gen2 #(.P_DEPTH(16), .A_DEPTH(4), .AUTO_INC(1'b1)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: buffers as queues, registers as plain variables.
    logic [15:0] mp_q[$];
    logic [15:0] ma_q[$];
    bit          mp_full = 0, ma_full = 0;
    logic [11:0] m_par_reg = '0, m_par = '0;
    logic [14:0] m_aar_reg = '0, m_aar = '0;
    logic [15:0] m_q = '0;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mp_q.delete();
            ma_q.delete();
            mp_full = 0; ma_full = 0;
            m_par_reg = '0; m_par = '0;
            m_aar_reg = '0; m_aar = '0;
            m_q = '0;
        end else begin
            bit pf0, af0;
            pf0 = mp_full;
            af0 = ma_full;
            if (bus.cpu_rden) begin
                case (bus.cpu_addr)
                    3'd0:    m_q = {4'h0, m_par_reg};
                    3'd1:    m_q = {1'b0, m_aar_reg};
                    3'd4:    m_q = {5'h0, 3'(ma_q.size()), 5'(mp_q.size()), 1'b0, ma_full, mp_full};
                    default: m_q = '0;
                endcase
            end
            if (bus.cpu_wren) begin
                case (bus.cpu_addr)
                    3'd0: m_par_reg = bus.cpu_data[11:0];
                    3'd1: m_aar_reg = bus.cpu_data[14:0] & 15'h7FFC;
                    3'd2: if (!pf0) begin
                        mp_q.push_back(bus.cpu_data);
                        if (mp_q.size() == 16) begin
                            mp_full = 1; m_par = m_par_reg; m_par_reg = m_par_reg + 12'd1;
                        end
                    end
                    3'd3: if (!af0) begin
                        ma_q.push_back(bus.cpu_data);
                        if (ma_q.size() == 4) begin
                            ma_full = 1; m_aar = m_aar_reg; m_aar_reg = m_aar_reg + 15'd4;
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.p_pop && pf0) begin
                void'(mp_q.pop_front());
                if (mp_q.size() == 0) mp_full = 0;
            end
            if (bus.a_pop && af0) begin
                void'(ma_q.pop_front());
                if (ma_q.size() == 0) ma_full = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("m_p_full", 32'(bus.p_full), 32'(mp_full));
            check("m_a_full", 32'(bus.a_full), 32'(ma_full));
            check("m_par", 32'(bus.par), 32'(m_par));
            check("m_aar", 32'(bus.aar), 32'(m_aar));
            check("m_cpu_q", 32'(bus.cpu_q), 32'(m_q));
            check("m_stall", 32'(bus.cpu_stall),
                  32'(bus.cpu_wren && ((bus.cpu_addr == 3'd2 && mp_full) ||
                                       (bus.cpu_addr == 3'd3 && ma_full))));
            if (mp_full) check("m_p_data", 32'(bus.p_data), 32'(mp_q[0]));
            if (ma_full) check("m_a_data", 32'(bus.a_data), 32'(ma_q[0]));
        end
    end

    task automatic drive(input bit wr, input bit rd, input logic [2:0] a,
                         input logic [15:0] d, input bit pp, input bit ap);
        bus.cpu_wren = wr;
        bus.cpu_rden = rd;
        bus.cpu_addr = a;
        bus.cpu_data = d;
        bus.p_pop    = pp;
        bus.a_pop    = ap;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(1'b1, 1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b0, 1'b1, a, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.cpu_wren = 0; bus.cpu_rden = 0; bus.cpu_addr = '0;
        bus.cpu_data = '0; bus.p_pop = 0; bus.a_pop = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_p_full", 32'(bus.p_full), 32'h0);
        check("rst_a_full", 32'(bus.a_full), 32'h0);
        check("rst_cpu_q", 32'(bus.cpu_q), 32'h0);
        check("rst_par", 32'(bus.par), 32'h0);
        check("rst_aar", 32'(bus.aar), 32'h0);

        // Fill a pattern tile and observe the 16-cycle fill latency.
        wr(3'd0, 16'h0123);
        for (int i = 0; i < 16; i++) begin
            wr(3'd2, 16'h1000 + 16'(i));
            if (i == 14) check("lat_p_full_early", 32'(bus.p_full), 32'h0);
        end
        check("t1_p_full", 32'(bus.p_full), 32'h1);
        check("t1_par", 32'(bus.par), 32'h123);
        check("t1_p_data", 32'(bus.p_data), 32'h1000);
        rd(3'd4);
        check("t1_status", 32'(bus.cpu_q), 32'h0081);
        rd(3'd0);
        check("t1_par_rd", 32'(bus.cpu_q), 32'h0124);

        // Drain it word by word.
        for (int i = 0; i < 16; i++) begin
            check("t2_p_data", 32'(bus.p_data), 32'h1000 + 32'(i));
            drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        end
        check("t2_p_full", 32'(bus.p_full), 32'h0);
        rd(3'd4);
        check("t2_status", 32'(bus.cpu_q), 32'h0000);

        // Stalled data write while draining, retried once the buffer empties.
        for (int i = 0; i < 16; i++) wr(3'd2, 16'h2000 + 16'(i));
        bus.cpu_wren = 1'b1; bus.cpu_addr = 3'd2; bus.cpu_data = 16'hDEAD;
        #1;
        check("t3_stall", 32'(bus.cpu_stall), 32'h1);
        @(posedge clk_sys);
        #1;
        rd(3'd4);
        check("t3_status_full", 32'(bus.cpu_q), 32'h0081);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        wr(3'd2, 16'hBEEF);
        rd(3'd4);
        check("t3_status_one", 32'(bus.cpu_q), 32'h0008);

        // Attribute fill with AAR wrap, PAR write during drain.
        wr(3'd1, 16'h7FFF);
        rd(3'd1);
        check("t4_aar_align", 32'(bus.cpu_q), 32'h7FFC);
        for (int i = 0; i < 4; i++) wr(3'd3, 16'hA000 + 16'(i));
        check("t4_a_full", 32'(bus.a_full), 32'h1);
        check("t4_aar", 32'(bus.aar), 32'h7FFC);
        check("t4_a_data", 32'(bus.a_data), 32'hA000);
        rd(3'd1);
        check("t4_aar_wrap", 32'(bus.cpu_q), 32'h0000);
        wr(3'd0, 16'h0055);
        check("t4_par_hold", 32'(bus.par), 32'h124);
        rd(3'd0);
        check("t4_par_rd", 32'(bus.cpu_q), 32'h0055);

        // Pattern fill concurrent with attribute drain, stray p_pop in fill.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 3'd2, 16'h3000 + 16'(i), 1'b1, 1'b1);
        check("t5_a_full", 32'(bus.a_full), 32'h0);
        check("t5_p_full", 32'(bus.p_full), 32'h0);
        rd(3'd4);
        check("t5_status", 32'(bus.cpu_q), 32'h0028);
        for (int i = 0; i < 11; i++) wr(3'd2, 16'h3004 + 16'(i));
        check("t5_p_full2", 32'(bus.p_full), 32'h1);
        check("t5_par", 32'(bus.par), 32'h055);
        check("t5_p_data", 32'(bus.p_data), 32'hBEEF);
        rd(3'd0);
        check("t5_par_rd", 32'(bus.cpu_q), 32'h0056);

        // Reset mid-fill and mid-drain.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) wr(3'd3, 16'hB000 + 16'(i));
        check("t6_aar", 32'(bus.aar), 32'h0000);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) wr(3'd2, 16'h4000 + 16'(i));
        rd(3'd4);
        check("t6_status_pre", 32'(bus.cpu_q), 32'h0342);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_a_full", 32'(bus.a_full), 32'h0);
        check("t6_rst_p_full", 32'(bus.p_full), 32'h0);
        check("t6_rst_cpu_q", 32'(bus.cpu_q), 32'h0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        idle(1);
        rd(3'd4);
        check("t6_status_post", 32'(bus.cpu_q), 32'h0000);
        rd(3'd0);
        check("t6_par_reg", 32'(bus.cpu_q), 32'h0000);
        rd(3'd1);
        check("t6_aar_reg", 32'(bus.cpu_q), 32'h0000);
        check("t6_par", 32'(bus.par), 32'h000);
        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
